// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : alu_pkg                                                    |
// | Function codes, FSM encoding and default width for alu_seq_core.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic [2:0] FN_ADD  = 3'd0;
    localparam logic [2:0] FN_SUB  = 3'd1;
    localparam logic [2:0] FN_MUL  = 3'd2;
    localparam logic [2:0] FN_SHL  = 3'd3;
    localparam logic [2:0] FN_SHR  = 3'd4;
    localparam logic [2:0] FN_ACC  = 3'd5;
    localparam logic [2:0] FN_HOLD = 3'd6;
    localparam logic [2:0] FN_CLR  = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : alu_seq_core_if                                          |
// | Operand/strobe inputs and result/handshake outputs of the ALU stage. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface alu_seq_core_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0]   Data;
    logic [2:0]         Function;
    logic               Enable;
    logic [2*WIDTH-1:0] ALUOut;
    logic               Busy;
    logic               Valid;

    modport master (
        output Data, Function, Enable,
        input  ALUOut, Busy, Valid
    );

    modport slave (
        input  Data, Function, Enable,
        output ALUOut, Busy, Valid
    );
endinterface
`default_nettype wire

// File: rtl/mul_shift_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mul_shift_add                                              |
// | Iterative shift-add multiplier, WIDTH iterations per product.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mul_shift_add
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               Clock,
    input  logic               Reset_b,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);
    localparam int MUL_CYCLES = WIDTH;
    localparam int CW         = $clog2(MUL_CYCLES + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // product includes the add of the current edge so the result can be
    // written on the final iteration edge rather than one cycle later
    assign acc_sum = acc + (mplier[0] ? mcand : '0);
    assign product = acc_sum;
    assign done    = (cnt == CW'(1));

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= (2*WIDTH)'(a);
            acc    <= '0;
            mplier <= b;
            cnt    <= CW'(MUL_CYCLES);
        end else if (cnt != '0) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_seq_core                                               |
// | Registered accumulator-style ALU with multi-cycle multiply.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          Clock,
    input  logic          Reset_b,
    alu_seq_core_if.slave bus
);
    localparam int            RW      = 2 * WIDTH;
    localparam logic [RW-1:0] SHL_LIM = RW'(RW);
    localparam logic [RW-1:0] SHR_LIM = RW'(WIDTH);

    state_t        state;
    state_t        state_nxt;
    logic [RW-1:0] alu_out;
    logic [RW-1:0] alu_nxt;
    logic [RW-1:0] single_res;
    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic [RW-1:0] mul_product;
    logic          valid;
    logic          valid_nxt;
    logic          busy;
    logic          busy_nxt;
    logic          mul_start;
    logic          mul_done;

    // B is always taken from the low half of our own result register
    assign a_ext = RW'(bus.Data);
    assign b_ext = RW'(alu_out[WIDTH-1:0]);

    always_comb begin
        single_res = alu_out;
        case (bus.Function)
            FN_ADD:  single_res = a_ext + b_ext;
            FN_SUB:  single_res = a_ext - b_ext;
            FN_SHL:  single_res = (a_ext >= SHL_LIM) ? '0 : (b_ext << bus.Data);
            FN_SHR:  single_res = (a_ext >= SHR_LIM) ? '0 : (b_ext >> bus.Data);
            FN_ACC:  single_res = alu_out + a_ext;
            FN_HOLD: single_res = alu_out;
            FN_CLR:  single_res = '0;
            default: single_res = alu_out;
        endcase
    end

    mul_shift_add #(
        .WIDTH (WIDTH)
    ) u_mul (
        .Clock   (Clock),
        .Reset_b (Reset_b),
        .start   (mul_start),
        .a       (bus.Data),
        .b       (alu_out[WIDTH-1:0]),
        .product (mul_product),
        .done    (mul_done)
    );

    always_comb begin
        state_nxt = state;
        alu_nxt   = alu_out;
        valid_nxt = 1'b0;
        mul_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.Enable) begin
                    if (bus.Function == FN_MUL) begin
                        mul_start = 1'b1;
                        state_nxt = ST_MUL;
                    end else begin
                        alu_nxt   = single_res;
                        valid_nxt = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    alu_nxt   = mul_product;
                    valid_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt == ST_MUL);
    end

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            state   <= ST_IDLE;
            alu_out <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            alu_out <= alu_nxt;
            valid   <= valid_nxt;
            busy    <= busy_nxt;
        end
    end

    assign bus.ALUOut = alu_out;
    assign bus.Busy   = busy;
    assign bus.Valid  = valid;

endmodule
`default_nettype wire
